// File: rtl/cluster_packer_pkg.sv
// Shared defaults, derived widths and FSM encoding for the iterative cluster packer.
package cluster_packer_pkg;

    localparam int DEF_MXROWS     = 8;
    localparam int DEF_MXKEYS     = 192;
    localparam int DEF_MXCLUSTERS = 8;
    localparam int DEF_MXCNTBITS  = 3;
    localparam int DEF_MXADRBITS  = $clog2(DEF_MXROWS * DEF_MXKEYS);
    localparam int DEF_MXCLSTBITS = DEF_MXCNTBITS + DEF_MXADRBITS;

    localparam logic [DEF_MXADRBITS-1:0] INVALID_ADR = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLAG,
        ST_ENCODE,
        ST_OUT
    } state_t;

endpackage

// File: rtl/cluster_packer_iter_priority_enc_dir.sv
// Find-first over a flat request vector; reverse=1 returns the highest set index.
module priority_enc_dir #(
    parameter  int WIDTH = 16,
    localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic             reverse,
    output logic             found,
    output logic [IDXW-1:0]  index
);

    always_comb begin
        found = |req;
        index = '0;
        if (reverse) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) index = IDXW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/cluster_packer_iter.sv
// Iterative S-bit cluster packer: flags cluster starts/sizes in one cycle, then
// extracts up to MXCLUSTERS clusters serially, one per clock.
module cluster_packer_iter
    import cluster_packer_pkg::*;
#(
    parameter  int MXROWS     = DEF_MXROWS,
    parameter  int MXKEYS     = DEF_MXKEYS,
    parameter  int MXCLUSTERS = DEF_MXCLUSTERS,
    parameter  int MXCNTBITS  = DEF_MXCNTBITS,
    localparam int MXADRBITS  = $clog2(MXROWS * MXKEYS),
    localparam int MXCLSTBITS = MXCNTBITS + MXADRBITS,
    localparam int CNTW       = $clog2(MXCLUSTERS + 1)
) (
    input  logic                             clock4x,
    input  logic                             global_reset_n,
    input  logic [MXROWS*MXKEYS-1:0]         sbits,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             truncate_clusters,
    input  logic                             reverse_priority_order,
    output logic [MXCLUSTERS*MXCLSTBITS-1:0] clusters,
    output logic                             out_valid,
    output logic [CNTW-1:0]                  out_count,
    output logic                             overflow,
    output logic [15:0]                      dropped
);

    localparam int NSB     = MXROWS * MXKEYS;
    localparam int MAXSIZE = 2 ** MXCNTBITS;
    localparam int PAD     = MAXSIZE + 1;
    localparam int SLOTW   = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
    localparam logic [CNTW-1:0] SLOT_FULL = CNTW'(MXCLUSTERS);
    localparam logic [MXCLSTBITS-1:0] INVALID_WORD = {{MXCNTBITS{1'b0}}, {MXADRBITS{1'b1}}};

    state_t                      state_reg;
    logic                        in_ready_reg;
    logic [NSB-1:0]              sbits_reg;
    logic                        trunc_reg;
    logic                        rev_reg;
    logic [NSB-1:0]              vpf_reg;
    logic [NSB*MXCNTBITS-1:0]    cnt_reg;
    logic [MXCLSTBITS-1:0]       slots_reg [MXCLUSTERS];
    logic [MXCLSTBITS-1:0]       slots_next [MXCLUSTERS];
    logic [CNTW-1:0]             slot_idx_reg;
    logic [MXCLSTBITS-1:0]       clusters_reg [MXCLUSTERS];
    logic                        out_valid_reg;
    logic [CNTW-1:0]             out_count_reg;
    logic                        overflow_reg;
    logic [15:0]                 dropped_reg;

    logic [NSB-1:0]              vpf_flag;
    logic [NSB*MXCNTBITS-1:0]    cnt_flag;

    // Each row is padded with zeros on both sides so off-row neighbours read as 0.
    for (genvar gi = 0; gi < MXROWS; gi++) begin : g_row
        logic [MXKEYS+2*PAD-1:0] row_pad;
        assign row_pad = {{PAD{1'b0}}, sbits_reg[gi*MXKEYS +: MXKEYS], {PAD{1'b0}}};

        for (genvar gj = 0; gj < MXKEYS; gj++) begin : g_key
            localparam int P = gj + PAD;
            logic [MXCNTBITS-1:0] cnt_c;

            always_comb begin
                logic run;
                run   = 1'b1;
                cnt_c = '0;
                for (int d = 1; d < MAXSIZE; d++) begin
                    run   = run & row_pad[P+d];
                    cnt_c = cnt_c + MXCNTBITS'(run);
                end
            end

            // Without truncation a run longer than MAXSIZE restarts after exactly MAXSIZE bits.
            assign vpf_flag[gi*MXKEYS+gj] = row_pad[P] &&
                (!row_pad[P-1] || (!trunc_reg && (&row_pad[P-1 -: MAXSIZE]) && !row_pad[P-1-MAXSIZE]));
            assign cnt_flag[(gi*MXKEYS+gj)*MXCNTBITS +: MXCNTBITS] = cnt_c;
        end
    end

    logic                   enc_found;
    logic [MXADRBITS-1:0]   enc_idx;
    logic [MXCLSTBITS-1:0]  enc_word;
    logic [NSB-1:0]         vpf_clr;
    logic [CNTW-1:0]        slot_inc;
    logic                   vpf_remain;
    logic                   enc_done;

    priority_enc_dir #(.WIDTH(NSB)) u_penc (
        .req     (vpf_reg),
        .reverse (rev_reg),
        .found   (enc_found),
        .index   (enc_idx)
    );

    always_comb begin
        enc_word = {cnt_reg[enc_idx*MXCNTBITS +: MXCNTBITS], enc_idx};
        vpf_clr  = vpf_reg;
        if (enc_found) vpf_clr[enc_idx] = 1'b0;
        vpf_remain = |vpf_clr;
        slot_inc   = slot_idx_reg + CNTW'(enc_found);
        enc_done   = !enc_found || !vpf_remain || (slot_inc == SLOT_FULL);
        for (int i = 0; i < MXCLUSTERS; i++) slots_next[i] = slots_reg[i];
        if (enc_found) slots_next[slot_idx_reg[SLOTW-1:0]] = enc_word;
    end

    // Output registers are loaded on the edge into OUT so they are valid alongside out_valid.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b0;
            sbits_reg     <= '0;
            trunc_reg     <= 1'b0;
            rev_reg       <= 1'b0;
            vpf_reg       <= '0;
            cnt_reg       <= '0;
            slot_idx_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            overflow_reg  <= 1'b0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                slots_reg[i]    <= INVALID_WORD;
                clusters_reg[i] <= INVALID_WORD;
            end
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        sbits_reg    <= sbits;
                        trunc_reg    <= truncate_clusters;
                        rev_reg      <= reverse_priority_order;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_FLAG;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                ST_FLAG: begin
                    vpf_reg      <= vpf_flag;
                    cnt_reg      <= cnt_flag;
                    slot_idx_reg <= '0;
                    for (int i = 0; i < MXCLUSTERS; i++) slots_reg[i] <= INVALID_WORD;
                    state_reg    <= ST_ENCODE;
                end
                ST_ENCODE: begin
                    vpf_reg      <= vpf_clr;
                    slot_idx_reg <= slot_inc;
                    for (int i = 0; i < MXCLUSTERS; i++) slots_reg[i] <= slots_next[i];
                    if (enc_done) begin
                        for (int i = 0; i < MXCLUSTERS; i++) clusters_reg[i] <= slots_next[i];
                        out_count_reg <= slot_inc;
                        overflow_reg  <= vpf_remain && (slot_inc == SLOT_FULL);
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            dropped_reg <= '0;
        end else if (in_valid && !in_ready_reg && (dropped_reg != 16'hFFFF)) begin
            dropped_reg <= dropped_reg + 16'd1;
        end
    end

    for (genvar gi = 0; gi < MXCLUSTERS; gi++) begin : g_out
        assign clusters[gi*MXCLSTBITS +: MXCLSTBITS] = clusters_reg[gi];
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign overflow  = overflow_reg;
    assign dropped   = dropped_reg;

endmodule
